exp_adder_arbiter: RTL and testbench
====================================

EXP_ADDER_ARBITER -- requirements
Module: exp_adder_arbiter

Interface
REQ-001 Parameters SHALL be: ES, default 3, exponent field width; K_BITS, default 6, regime k width; MAX_BITS, default ES+K_BITS, result MSB index; TIMEOUT, default 16, maximum cycles spent in WAIT.
REQ-002 The ports SHALL be as follows. One clock, clk; reset rst_n is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req0, req1  in  1 each  level request, held with operands until the matching ack
- k0_A, k0_B, k1_A, k1_B  in  K_BITS each  requester signed regime k
- e0_A, e0_B, e1_A, e1_B  in  ES each  requester exponent fields
- s0_A, s0_B, s1_A, s1_B  in  1 each  requester signs
- ack0, ack1  out  1 each  one-cycle completion pulse; result bus valid in the same cycle
- res_exp  out  MAX_BITS+1  captured exp_raw
- res_sign, res_nar, res_zero  out  1 each  captured adder flags
- res_err  out  1  timeout indicator
- res_id  out  1  requester that was served
- busy  out  1  high whenever the state is not IDLE
- adder_start  out  1  start pulse to the shared exp_adder
- adder_valid_out  out  1  release pulse returning the adder to its IDLE state
- adder_k_A, adder_k_B  out  K_BITS each  operands to the adder
- adder_exp_A, adder_exp_B  out  ES each  operands to the adder
- adder_sign_A, adder_sign_B  out  1 each  operands to the adder
- adder_exp_raw  in  MAX_BITS+1  adder result
- adder_sign_out, adder_NaR, adder_zero_out, adder_done  in  1 each  adder status

Function
REQ-003 The FSM SHALL have the states IDLE, ISSUE, WAIT, RELEASE and COOL, registered, with all outputs registered.
REQ-004 IDLE SHALL move to ISSUE when (req0|req1) and !adder_done; in every other case it SHALL remain in IDLE.
REQ-005 Arbitration SHALL be round-robin:
- One request pending: that requester wins.
- Both pending: the requester whose id differs from last_id wins.
- last_id SHALL update to the served id in RELEASE.
REQ-006 On the IDLE to ISSUE transition, the winner's six operands SHALL be latched onto the adder_* operand outputs and its id into owner. The latched values SHALL hold stable until the next grant, and later requester input changes SHALL be ignored.
REQ-007 In ISSUE, adder_start SHALL be 1 for exactly one cycle, and the next state SHALL be WAIT.
REQ-008 In WAIT, an 8-bit watchdog counter SHALL clear on entry and increment on each WAIT cycle that has adder_done=0.
REQ-009 In WAIT, adder_done=1 SHALL capture adder_exp_raw, adder_sign_out, adder_NaR and adder_zero_out into res_*, clear res_err, and move to RELEASE.
REQ-010 In WAIT, when the watchdog counter equals TIMEOUT-1 and adder_done=0, the block SHALL set res_err=1, res_nar=1, res_zero=0, res_exp=0 and res_sign=0, and move to RELEASE.
REQ-011 adder_done and timeout in the same cycle SHALL resolve as done: the result is captured and res_err=0.
REQ-012 In RELEASE, for exactly one cycle:
- adder_valid_out SHALL be 1.
- ack[owner] SHALL be 1.
- res_id SHALL equal owner.
- The next state SHALL be COOL.
REQ-013 COOL SHALL last exactly one cycle and then go to IDLE, so that the served requester can drop req before it is sampled again.
REQ-014 res_* SHALL hold their values until the next capture.
REQ-015 ack0 and ack1 SHALL never be high together, and adder_start and adder_valid_out SHALL never be high together.
REQ-016 Minimum request-to-ack latency SHALL be 4 cycles, with adder_done arriving in the first WAIT cycle.

Reset
REQ-017 While rst_n=0, and immediately on its assertion, the following SHALL hold:
- state=IDLE.
- All outputs 0.
- last_id=1, so requester 0 wins the first tie.
- Watchdog counter 0.
REQ-018 Reset asserted in any state, including mid-WAIT, SHALL abort the operation with no ack.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- req0 alone, k=2/e=3 and k=1/e=2, adder model returns done 2 cycles after start with exp_raw=37 -> one adder_start, one adder_valid_out, ack0 one cycle, res_exp=37, res_id=0, res_err=0.
- req0 and req1 asserted together after reset, each held until its ack -> ack0 first, then ack1. Both re-asserted -> ack0 first again (last_id=1).
- Adder never asserts done -> after 16 WAIT cycles: ack with res_err=1, res_nar=1, res_exp=0, and adder_valid_out pulsed once.
- Adder returns NaR=1, or zero_out=1 with sign_out=1 -> res_nar, res_zero and res_sign pass through exactly.
- adder_done held high for 3 cycles into IDLE while req1 pending -> adder_start asserted only after adder_done falls.
- rst_n pulled low mid-WAIT -> all outputs 0 immediately, no ack. After release, a pending req0 is served normally.

Source files
------------

// File: rtl/exp_adder_arbiter_if.sv
// Requester-side and adder-side signals of the shared exp_adder arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface exp_adder_arbiter_if #(
  parameter int unsigned ES       = 3,
  parameter int unsigned K_BITS   = 6,
  parameter int unsigned MAX_BITS = ES + K_BITS
);
  logic              req0, req1;
  logic [K_BITS-1:0] k0_A, k0_B, k1_A, k1_B;
  logic [ES-1:0]     e0_A, e0_B, e1_A, e1_B;
  logic              s0_A, s0_B, s1_A, s1_B;

  logic              ack0, ack1;
  logic [MAX_BITS:0] res_exp;
  logic              res_sign, res_nar, res_zero, res_err, res_id;
  logic              busy;

  logic              adder_start, adder_valid_out;
  logic [K_BITS-1:0] adder_k_A, adder_k_B;
  logic [ES-1:0]     adder_exp_A, adder_exp_B;
  logic              adder_sign_A, adder_sign_B;

  logic [MAX_BITS:0] adder_exp_raw;
  logic              adder_sign_out, adder_NaR, adder_zero_out, adder_done;

  modport slave (
    input  req0, req1, k0_A, k0_B, k1_A, k1_B, e0_A, e0_B, e1_A, e1_B,
    input  s0_A, s0_B, s1_A, s1_B,
    input  adder_exp_raw, adder_sign_out, adder_NaR, adder_zero_out, adder_done,
    output ack0, ack1, res_exp, res_sign, res_nar, res_zero, res_err, res_id, busy,
    output adder_start, adder_valid_out, adder_k_A, adder_k_B,
    output adder_exp_A, adder_exp_B, adder_sign_A, adder_sign_B
  );

  modport master (
    output req0, req1, k0_A, k0_B, k1_A, k1_B, e0_A, e0_B, e1_A, e1_B,
    output s0_A, s0_B, s1_A, s1_B,
    output adder_exp_raw, adder_sign_out, adder_NaR, adder_zero_out, adder_done,
    input  ack0, ack1, res_exp, res_sign, res_nar, res_zero, res_err, res_id, busy,
    input  adder_start, adder_valid_out, adder_k_A, adder_k_B,
    input  adder_exp_A, adder_exp_B, adder_sign_A, adder_sign_B
  );
endinterface

// File: rtl/exp_adder_arbiter.sv
// Round-robin arbiter sharing one exp_adder between two requesters, with a WAIT
// watchdog that turns a hung adder into an error result.
module exp_adder_arbiter #(
  parameter int unsigned ES       = 3,
  parameter int unsigned K_BITS   = 6,
  parameter int unsigned MAX_BITS = ES + K_BITS,
  parameter int unsigned TIMEOUT  = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  exp_adder_arbiter_if.slave  bus
);
  typedef enum logic [2:0] {StIdle, StIssue, StWait, StRelease, StCool} state_e;

  localparam logic [7:0] WdogLast = 8'(TIMEOUT - 1);

  state_e            state_q;
  logic              last_id_q, owner_q;
  logic [7:0]        wdog_q;

  logic              grant_id;
  logic [K_BITS-1:0] win_k_a, win_k_b;
  logic [ES-1:0]     win_e_a, win_e_b;
  logic              win_s_a, win_s_b;

  // On a tie the requester not served last time wins.
  always_comb begin
    grant_id = (bus.req0 && bus.req1) ? !last_id_q : bus.req1;
    win_k_a  = grant_id ? bus.k1_A : bus.k0_A;
    win_k_b  = grant_id ? bus.k1_B : bus.k0_B;
    win_e_a  = grant_id ? bus.e1_A : bus.e0_A;
    win_e_b  = grant_id ? bus.e1_B : bus.e0_B;
    win_s_a  = grant_id ? bus.s1_A : bus.s0_A;
    win_s_b  = grant_id ? bus.s1_B : bus.s0_B;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= StIdle;
      last_id_q           <= 1'b1;
      owner_q             <= 1'b0;
      wdog_q              <= 8'd0;
      bus.ack0            <= 1'b0;
      bus.ack1            <= 1'b0;
      bus.res_exp         <= {(MAX_BITS + 1){1'b0}};
      bus.res_sign        <= 1'b0;
      bus.res_nar         <= 1'b0;
      bus.res_zero        <= 1'b0;
      bus.res_err         <= 1'b0;
      bus.res_id          <= 1'b0;
      bus.busy            <= 1'b0;
      bus.adder_start     <= 1'b0;
      bus.adder_valid_out <= 1'b0;
      bus.adder_k_A       <= '0;
      bus.adder_k_B       <= '0;
      bus.adder_exp_A     <= '0;
      bus.adder_exp_B     <= '0;
      bus.adder_sign_A    <= 1'b0;
      bus.adder_sign_B    <= 1'b0;
    end else begin
      bus.adder_start     <= 1'b0;
      bus.adder_valid_out <= 1'b0;
      bus.ack0            <= 1'b0;
      bus.ack1            <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A lingering done from the previous operation blocks a new grant.
          if ((bus.req0 || bus.req1) && !bus.adder_done) begin
            state_q          <= StIssue;
            owner_q          <= grant_id;
            bus.adder_k_A    <= win_k_a;
            bus.adder_k_B    <= win_k_b;
            bus.adder_exp_A  <= win_e_a;
            bus.adder_exp_B  <= win_e_b;
            bus.adder_sign_A <= win_s_a;
            bus.adder_sign_B <= win_s_b;
            bus.adder_start  <= 1'b1;
            bus.busy         <= 1'b1;
          end
        end
        StIssue: begin
          state_q <= StWait;
          wdog_q  <= 8'd0;
        end
        StWait: begin
          if (!bus.adder_done) wdog_q <= wdog_q + 8'd1;
          if (bus.adder_done || (wdog_q == WdogLast)) begin
            state_q             <= StRelease;
            bus.adder_valid_out <= 1'b1;
            bus.ack0            <= !owner_q;
            bus.ack1            <= owner_q;
            bus.res_id          <= owner_q;
            // Done wins over a simultaneous timeout.
            if (bus.adder_done) begin
              bus.res_exp  <= bus.adder_exp_raw;
              bus.res_sign <= bus.adder_sign_out;
              bus.res_nar  <= bus.adder_NaR;
              bus.res_zero <= bus.adder_zero_out;
              bus.res_err  <= 1'b0;
            end else begin
              bus.res_exp  <= {(MAX_BITS + 1){1'b0}};
              bus.res_sign <= 1'b0;
              bus.res_nar  <= 1'b1;
              bus.res_zero <= 1'b0;
              bus.res_err  <= 1'b1;
            end
          end
        end
        StRelease: begin
          state_q   <= StCool;
          last_id_q <= owner_q;
        end
        StCool: begin
          state_q  <= StIdle;
          bus.busy <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_exp_adder_arbiter.sv
// Scoreboard bench for exp_adder_arbiter: a stimulus process queues expected
// transactions, an adder model serves starts, a monitor checks every ack.
module tb_exp_adder_arbiter;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic       id;
    logic [5:0] k_A, k_B;
    logic [2:0] e_A, e_B;
    logic       s_A, s_B;
    int         delay;  // cycles from start to done; 0 means the adder never answers
    logic [9:0] exp;
    logic       sign, nar, zero;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   hold_until = 0;
  logic m_last = 1'b1;

  txn_t exp_q[$];
  txn_t adder_q[$];

  exp_adder_arbiter_if bus ();

  exp_adder_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic txn_t make_txn(input logic id, input int d);
    txn_t t;
    t.id    = id;
    t.k_A   = 6'($urandom);
    t.k_B   = 6'($urandom);
    t.e_A   = 3'($urandom);
    t.e_B   = 3'($urandom);
    t.s_A   = 1'($urandom);
    t.s_B   = 1'($urandom);
    t.delay = d;
    t.exp   = 10'($urandom);
    t.sign  = 1'($urandom);
    t.nar   = 1'($urandom);
    t.zero  = 1'($urandom);
    return t;
  endfunction

  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(0, 11));
    if (r == 0) return 0;
    if (r == 11) return 16;
    if (r == 10) return 1;
    return r;
  endfunction

  function automatic logic is_err(input txn_t t);
    return (t.delay == 0) || (t.delay > TIMEOUT);
  endfunction

  // {res_exp, res_sign, res_nar, res_zero, res_err}
  function automatic logic [13:0] expect_res(input txn_t t);
    if (is_err(t)) return {10'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    return {t.exp, t.sign, t.nar, t.zero, 1'b0};
  endfunction

  function automatic int expect_lat(input txn_t t);
    return is_err(t) ? TIMEOUT + 1 : t.delay + 1;
  endfunction

  function automatic logic [63:0] out_vec();
    return 64'({bus.ack0, bus.ack1, bus.res_exp, bus.res_sign, bus.res_nar, bus.res_zero,
                bus.res_err, bus.res_id, bus.busy, bus.adder_start, bus.adder_valid_out,
                bus.adder_k_A, bus.adder_k_B, bus.adder_exp_A, bus.adder_exp_B,
                bus.adder_sign_A, bus.adder_sign_B});
  endfunction

  task automatic push(input txn_t t);
    exp_q.push_back(t);
    adder_q.push_back(t);
  endtask

  task automatic drive_ops(input txn_t t);
    if (t.id) begin
      bus.k1_A = t.k_A; bus.k1_B = t.k_B; bus.e1_A = t.e_A; bus.e1_B = t.e_B;
      bus.s1_A = t.s_A; bus.s1_B = t.s_B;
    end else begin
      bus.k0_A = t.k_A; bus.k0_B = t.k_B; bus.e0_A = t.e_A; bus.e0_B = t.e_B;
      bus.s0_A = t.s_A; bus.s0_B = t.s_B;
    end
  endtask

  task automatic wait_acks(input logic [1:0] mask);
    logic [1:0] pending;
    int n;
    pending = mask;
    n = 0;
    while (pending != 2'b00 && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.ack0 && pending[0]) begin pending[0] = 1'b0; bus.req0 = 1'b0; end
      if (bus.ack1 && pending[1]) begin pending[1] = 1'b0; bus.req1 = 1'b0; end
    end
    check("acks_within_bound", 64'(pending), 64'd0);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    check("busy_cool", 64'(bus.busy), 64'd1);
    @(negedge clk);
    check("busy_idle", 64'(bus.busy), 64'd0);
  endtask

  // Service order comes from the round-robin rule applied to the pending set.
  task automatic run_round(input logic [1:0] mask, input txn_t t0, input txn_t t1);
    logic first;
    first = (mask == 2'b11) ? !m_last : mask[1];
    push(first ? t1 : t0);
    if (mask == 2'b11) begin
      push(first ? t0 : t1);
      m_last = !first;
    end else begin
      m_last = first;
    end
    @(negedge clk);
    drive_ops(t0);
    drive_ops(t1);
    bus.req0 = mask[0];
    bus.req1 = mask[1];
    wait_acks(mask);
  endtask

  initial begin : adder_model
    txn_t cur;
    int   cnt;
    logic done_r;
    cnt    = 0;
    done_r = 1'b0;
    cur    = make_txn(1'b0, 0);
    bus.adder_done     = 1'b0;
    bus.adder_exp_raw  = '0;
    bus.adder_sign_out = 1'b0;
    bus.adder_NaR      = 1'b0;
    bus.adder_zero_out = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        cnt    = 0;
        done_r = 1'b0;
      end else begin
        if (bus.adder_valid_out) done_r = 1'b0;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) done_r = 1'b1;
        end
        if (bus.adder_start) begin
          if (adder_q.size() == 0) begin
            fail_now("adder_start_unexpected");
          end else begin
            cur = adder_q.pop_front();
            check("operands",
                  64'({bus.adder_k_A, bus.adder_k_B, bus.adder_exp_A, bus.adder_exp_B,
                       bus.adder_sign_A, bus.adder_sign_B}),
                  64'({cur.k_A, cur.k_B, cur.e_A, cur.e_B, cur.s_A, cur.s_B}));
            cnt = cur.delay;
          end
        end
      end
      bus.adder_done = done_r || (cyc < hold_until);
      if (done_r) begin
        bus.adder_exp_raw  = cur.exp;
        bus.adder_sign_out = cur.sign;
        bus.adder_NaR      = cur.nar;
        bus.adder_zero_out = cur.zero;
      end else begin
        bus.adder_exp_raw  = 10'($urandom);
        bus.adder_sign_out = 1'($urandom);
        bus.adder_NaR      = 1'($urandom);
        bus.adder_zero_out = 1'($urandom);
      end
    end
  end

  initial begin : monitor
    txn_t        t;
    logic [13:0] got;
    logic [13:0] last_res;
    int          starts;
    int          start_cyc;
    last_res  = '0;
    starts    = 0;
    start_cyc = 0;
    forever begin
      @(negedge clk);
      got = {bus.res_exp, bus.res_sign, bus.res_nar, bus.res_zero, bus.res_err};
      if (!rst_n) begin
        starts   = 0;
        last_res = '0;
      end else begin
        if (bus.adder_start) begin
          starts++;
          start_cyc = cyc;
        end
        check("exclusive_pulses",
              64'({bus.ack0 & bus.ack1, bus.adder_start & bus.adder_valid_out}), 64'd0);
        check("valid_out_with_ack", 64'(bus.adder_valid_out), 64'(bus.ack0 | bus.ack1));
        if (bus.ack0 || bus.ack1) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_ack");
          end else begin
            t = exp_q.pop_front();
            check("ack_line", 64'({bus.ack1, bus.ack0}), t.id ? 64'd2 : 64'd1);
            check("res_id", 64'(bus.res_id), 64'(t.id));
            check("result", 64'(got), 64'(expect_res(t)));
            check("latency", 64'(cyc - start_cyc), 64'(expect_lat(t)));
            check("starts_per_ack", 64'(starts), 64'd1);
          end
          starts   = 0;
          last_res = got;
        end else begin
          check("res_hold", 64'(got), 64'(last_res));
        end
      end
    end
  end

  initial begin : global_bound
    #500000;
    $display("FAIL global_time_bound (cycle %0d)", cyc);
    $fatal(1, "simulation time bound expired");
  end

  initial begin : stimulus
    txn_t t0, t1;
    int   n;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    drive_ops(make_txn(1'b0, 0));
    drive_ops(make_txn(1'b1, 0));

    #1 rst_n = 1'b0;
    #2 check("reset_outputs", out_vec(), 64'd0);
    repeat (3) @(negedge clk);
    check("reset_outputs_held", out_vec(), 64'd0);
    rst_n = 1'b1;

    // Ties right after reset: requester 0 first, both times.
    run_round(2'b11, make_txn(1'b0, 1), make_txn(1'b1, 1));
    run_round(2'b11, make_txn(1'b0, 2), make_txn(1'b1, 1));

    t0 = make_txn(1'b0, 2);
    t0.k_A = 6'd2; t0.e_A = 3'd3; t0.k_B = 6'd1; t0.e_B = 3'd2;
    t0.s_A = 1'b0; t0.s_B = 1'b0;
    t0.exp = 10'd37; t0.sign = 1'b0; t0.nar = 1'b0; t0.zero = 1'b0;
    run_round(2'b01, t0, make_txn(1'b1, 1));

    run_round(2'b01, make_txn(1'b0, 0), make_txn(1'b1, 1));
    run_round(2'b10, make_txn(1'b0, 1), make_txn(1'b1, 16));

    t0 = make_txn(1'b0, 3);
    t0.nar = 1'b1; t0.zero = 1'b0; t0.sign = 1'b0;
    run_round(2'b01, t0, make_txn(1'b1, 1));
    t1 = make_txn(1'b1, 2);
    t1.nar = 1'b0; t1.zero = 1'b1; t1.sign = 1'b1;
    run_round(2'b10, make_txn(1'b0, 1), t1);

    // adder_done stuck high for 3 cycles while req1 waits in IDLE.
    @(negedge clk);
    hold_until = cyc + 4;
    t1 = make_txn(1'b1, 1);
    push(t1);
    m_last = 1'b1;
    @(posedge clk);
    #2;
    drive_ops(t1);
    bus.req1 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_start_while_done", 64'({bus.adder_start, bus.busy}), 64'd0);
    end
    wait_acks(2'b10);

    // Reset in the middle of WAIT aborts without an ack.
    t0 = make_txn(1'b0, 0);
    adder_q.push_back(t0);
    @(negedge clk);
    drive_ops(t0);
    bus.req0 = 1'b1;
    n = 0;
    while (!bus.adder_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reached_issue", 64'(bus.adder_start), 64'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1 check("reset_mid_wait_outputs", out_vec(), 64'd0);
    repeat (2) @(negedge clk);
    check("reset_mid_wait_held", out_vec(), 64'd0);
    t0.delay = 1;
    push(t0);
    m_last = 1'b0;
    rst_n = 1'b1;
    wait_acks(2'b01);

    for (int i = 0; i < 40; i++) begin
      run_round(2'($urandom_range(1, 3)), make_txn(1'b0, pick_delay()),
                make_txn(1'b1, pick_delay()));
    end

    repeat (5) @(negedge clk);
    check("expected_queue_drained", 64'(exp_q.size()), 64'd0);
    check("adder_queue_drained", 64'(adder_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
